inv_shift_rows_loader: RTL
==========================

# inv_shift_rows_loader

Byte-serial AES InvShiftRows stage for the decryption datapath. It accepts a 16-byte state one byte per cycle in column-major order and writes each byte directly to its InvShiftRows-permuted position. It presents the finished 128-bit state on a valid/ready port. Two ping-pong banks let the next block load while the previous block waits for the downstream round logic.

## Interface
- Parameters: none. Sizes are fixed by AES; constants live in the package.
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  byte on in_byte is valid
- in_ready  out  1  block can accept a byte this cycle
- in_byte  in  8  state byte; stream index k = 4*col + row
- in_last  in  1  marks byte 15 of a block
- out_valid  out  1  State_Out holds a complete permuted state
- out_ready  in  1  downstream consumes State_Out
- State_Out  out  [0:127]  result; byte k occupies bits 8k..8k+7
- frame_err  out  1  one-cycle pulse on in_last framing mismatch
- decrypt  in  1  present only with AES_SHIFT_DIR_SEL_EN (see Configuration)

## Operation
- Input byte k (row r=k%4, col c=k/4) is written to output byte 4*((c+r)%4)+r, i.e. out[r][c] = in[r][(c-r)%4].
- A 4-bit byte counter advances on each accepted byte (in_valid & in_ready) and wraps 15→0.
- Banks:
  - Write bank selected by wr_sel, read bank by rd_sel.
  - Each bank has a full flag.
  - in_ready = ~full[wr_sel] & ~reset.
  - out_valid = full[rd_sel].
  - State_Out = bank[rd_sel], driven straight from registers.
- Completion: byte 15 accepted → full[wr_sel] set, wr_sel toggles.
- Release: out_valid & out_ready → full[rd_sel] cleared, rd_sel toggles.
- Completion and release in the same cycle are both applied. They can only target different banks.
- Framing:
  - in_last on an accepted byte with counter ≠15: frame_err pulses, the partial block is discarded, counter returns to 0, and the bank contents are don't-care until overwritten.
  - Byte 15 accepted without in_last: frame_err pulses, the block still completes normally.
- Both banks full: in_ready=0, and bytes are held off upstream. The counter is unaffected.
- Reset values: banks and State_Out 128'h0, out_valid 0, frame_err 0, counter 0, wr_sel=rd_sel=0, full=2'b00.

## Timing
- in_ready is 0 while reset is high and 1 from the first cycle after reset.
- Byte 15 accepted at edge N → out_valid=1 and State_Out valid in the cycle after N. Latency is 1 cycle from the last byte.
- Sustained throughput is 1 byte/cycle with no bubble between blocks as long as out_ready keeps up. Each block takes 16 cycles.
- State_Out and out_valid are stable while out_valid=1 and out_ready=0.
- frame_err is registered and asserts the cycle after the offending byte.
- Reset mid-block discards all partial and complete data. The next block starts at counter 0.

## Configuration
- AES_SHIFT_DIR_SEL_EN defined:
  - The decrypt input exists and is sampled with byte 0 of each block, held for that block.
  - decrypt=1 gives InvShiftRows.
  - decrypt=0 gives forward ShiftRows: byte k goes to 4*((c-r)%4)+r.
- Undefined: no decrypt port, InvShiftRows only.

## Structure
- Package aes_pkg:
  - AES_NB_BYTES=16.
  - byte_t typedef (8-bit).
  - state_t typedef ([0:127]).
  - Functions inv_sr_idx(k) and fwd_sr_idx(k) returning the 4-bit destination index.
- Sub-module sr_state_bank: one 128-bit register bank with a byte write enable and 4-bit write index plus synchronous clear. Instantiated twice.

## Test plan
- Basic inverse: bytes 0x00..0x0f with in_last on 0x0f, out_ready=1 → State_Out bytes 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03, out_valid for 1 cycle.
- Ping-pong back-pressure: 3 back-to-back blocks with out_ready=0 → in_ready drops after 32 bytes. Raising out_ready then drains block 1 then block 2 in order, and block 3 resumes loading.
- Early in_last: in_last on byte 5 → frame_err pulses once. The next 16 bytes form a correct block, and out_valid does not assert for the partial block.
- Missing in_last: 16 bytes with no in_last → frame_err pulse and the output still equals the expected permutation.
- Reset mid-block and mid-output: reset during byte 8 and again while out_valid=1 → all outputs are 0 the next cycle, and a fresh block loads correctly.
- With AES_SHIFT_DIR_SEL_EN and decrypt=0, bytes 0x00..0x0f → 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. Alternating decrypt per block gives the matching result for each.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES byte-serial types and ShiftRows index helpers.
// Used by inv_shift_rows_loader and sr_state_bank.
package aes_pkg;

  localparam int AES_NB_BYTES = 16;

  typedef logic [7:0]   byte_t;
  typedef logic [0:127] state_t;

  // k = 4*col + row; column index wraps mod 4 in 2 bits
  function automatic logic [3:0] inv_sr_idx(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] d;
    r = k[1:0];
    c = k[3:2];
    d = c + r;
    return {d, r};
  endfunction

  function automatic logic [3:0] fwd_sr_idx(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] d;
    r = k[1:0];
    c = k[3:2];
    d = c - r;
    return {d, r};
  endfunction

endpackage

// File: rtl/sr_state_bank.sv
// One 128-bit state bank with byte write at a 4-bit index.
// Synchronous clear has priority over the write.
module sr_state_bank
  import aes_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       we,
  input  logic [3:0] widx,
  input  byte_t      wdata,
  output state_t     state
);

  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = '0;
    end else if (we) begin
      state_d[{widx, 3'b000} +: 8] = wdata;
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/inv_shift_rows_loader.sv
// Byte-serial InvShiftRows loader with ping-pong banks.
// AES_SHIFT_DIR_SEL_EN adds a per-block decrypt select.
module inv_shift_rows_loader
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] State_Out,
  output logic         frame_err
`ifdef AES_SHIFT_DIR_SEL_EN
  ,
  input  logic         decrypt
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(AES_NB_BYTES - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [1:0] full_q, full_d;
  logic       ferr_q, ferr_d;

  logic       acc;
  logic       rel;
  logic [3:0] widx;
  state_t     bank0;
  state_t     bank1;

  assign in_ready  = ~full_q[wr_sel_q] & ~reset;
  assign out_valid = full_q[rd_sel_q];
  assign State_Out = rd_sel_q ? bank1 : bank0;
  assign frame_err = ferr_q;

  assign acc = in_valid & in_ready;
  assign rel = out_valid & out_ready;

`ifdef AES_SHIFT_DIR_SEL_EN
  logic dir_q, dir_d;
  logic dir_cur;

  // byte 0 uses the live input; later bytes use the latched one
  assign dir_cur = (cnt_q == 4'd0) ? decrypt : dir_q;
  assign dir_d   = (acc && cnt_q == 4'd0) ? decrypt : dir_q;
  assign widx    = dir_cur ? inv_sr_idx(cnt_q) : fwd_sr_idx(cnt_q);

  always_ff @(posedge clock) begin
    if (reset) dir_q <= 1'b1;
    else       dir_q <= dir_d;
  end
`else
  assign widx = inv_sr_idx(cnt_q);
`endif

  always_comb begin
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    full_d   = full_q;
    ferr_d   = 1'b0;
    if (acc) begin
      if (in_last && cnt_q != LAST_IDX) begin
        ferr_d = 1'b1;
        cnt_d  = 4'd0;
      end else if (cnt_q == LAST_IDX) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        cnt_d            = 4'd0;
        ferr_d           = ~in_last;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    if (rel) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= 2'b00;
      ferr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      ferr_q   <= ferr_d;
    end
  end

  sr_state_bank u_bank0 (
    .clock (clock),
    .clear (reset),
    .we    (acc & ~wr_sel_q),
    .widx  (widx),
    .wdata (in_byte),
    .state (bank0)
  );

  sr_state_bank u_bank1 (
    .clock (clock),
    .clear (reset),
    .we    (acc & wr_sel_q),
    .widx  (widx),
    .wdata (in_byte),
    .state (bank1)
  );

endmodule
